// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 slave terminating 32-bit frames against a 16-bit register file
module spi_slave_regfile #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk_in,
  input  logic        spi_mosi_in,
  input  logic        spi_cs_n_in,
  output logic        spi_miso_out,
  output logic        spi_miso_oe,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  input  logic [7:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE,
    S_WAIT_CS
  } state_e;

  // Address decode shared by the SPI command path and the debug port.
  function automatic logic addr_ok(input logic [7:0] a);
    return int'({24'd0, a}) < DEPTH;
  endfunction

  // Pin synchronizers: two flops to settle, a third on sclk/cs_n for edge detect.
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  // Resynchronise the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk_in};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n_in};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_in};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_high;
  logic mosi_bit;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_high   = cs_sync_q[1];
  assign mosi_bit  = mosi_sync_q[1];

  logic [15:0] regs_q [DEPTH];

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [14:0] cmd_sr_q, cmd_sr_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic [15:0] tx_sr_q, tx_sr_d;
  logic [7:0]  addr_q, addr_d;
  logic        is_wr_q, is_wr_d;
  logic        err_q, err_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic        reg_we;
  logic [15:0] cmd_next;

  // Frame FSM: next state, shift registers and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_sr_d    = cmd_sr_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    err_d       = err_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    reg_we      = 1'b0;
    cmd_next    = {cmd_sr_q, mosi_bit};

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        oe_d   = 1'b0;
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = S_CMD;
          oe_d    = 1'b1;
          err_d   = 1'b0;
        end
      end

      S_CMD: begin
        if (cs_high) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          oe_d        = 1'b0;
          miso_d      = 1'b0;
          cnt_d       = '0;
        end else if (sclk_rise) begin
          cmd_sr_d = cmd_next[14:0];
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            addr_d  = cmd_next[7:0];
            is_wr_d = cmd_next[15];
            err_d   = ~addr_ok(cmd_next[7:0]);
            tx_sr_d = 16'h0000;
            if (!cmd_next[15] && addr_ok(cmd_next[7:0])) begin
              tx_sr_d = regs_q[cmd_next[AW-1:0]];
            end
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // The 32nd rise wins over a simultaneous cs_n rise so the frame completes.
        if (sclk_rise && cnt_q == 6'd31) begin
          rx_sr_d = {rx_sr_q[14:0], mosi_bit};
          cnt_d   = cnt_q + 6'd1;
          state_d = S_DONE;
        end else if (cs_high) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          oe_d        = 1'b0;
          miso_d      = 1'b0;
          cnt_d       = '0;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[14:0], mosi_bit};
          cnt_d   = cnt_q + 6'd1;
        end else if (sclk_fall) begin
          miso_d  = tx_sr_q[15];
          tx_sr_d = {tx_sr_q[14:0], 1'b0};
        end
      end

      S_DONE: begin
        miso_d      = 1'b0;
        frame_err_d = err_q;
        if (is_wr_q && !err_q) begin
          reg_we      = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = rx_sr_q;
        end
        state_d = S_WAIT_CS;
      end

      S_WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_high) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Frame FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_sr_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      err_q       <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      err_q       <= err_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file: commits in the same clk that raises wr_strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (reg_we) begin
      regs_q[addr_q[AW-1:0]] <= rx_sr_q;
    end
  end

  // Debug read port: combinational, zero outside the legal address range.
  always_comb begin
    dbg_data = 16'h0000;
    if (addr_ok(dbg_addr)) begin
      dbg_data = regs_q[dbg_addr[AW-1:0]];
    end
  end

  assign spi_miso_out = miso_q;
  assign spi_miso_oe  = oe_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - scoreboard bench for spi_slave_regfile
module tb_spi_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic        miso_oe;
  logic        wr_strobe;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_data;

  int tests_run = 0;
  int tests_failed = 0;
  int err_seen = 0;
  int wr_seen = 0;
  int err_exp = 0;
  int wr_exp = 0;

  logic [23:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [15:0] model_regs [16];
  logic        oe_mid;
  logic [15:0] rd;

  always #5 clk = ~clk;

  spi_slave_regfile #(.DEPTH(16), .RESET_VAL(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk_in (sclk),
    .spi_mosi_in (mosi),
    .spi_cs_n_in (cs_n),
    .spi_miso_out(miso),
    .spi_miso_oe (miso_oe),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_err   (frame_err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write-commit scoreboard and error pulse counter, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        check("wr_commit", {8'd0, wr_addr, wr_data}, {8'd0, exp_wr.pop_front()});
      end
    end
    if (rst_n && frame_err) err_seen++;
  end

  task automatic dbg_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  // Master side of one frame: mode 0, half period 4 clk; optional reset at bit 24.
  task automatic spi_xfer(input logic [15:0] cmd, input logic [15:0] data, input int nbits,
                          input bit rst_at_24, output logic [15:0] rdata);
    logic [31:0] word;
    bit          hit_rst;
    word    = {cmd, data};
    rdata   = 16'h0000;
    hit_rst = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (rst_at_24 && i == 24) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("oe_in_reset", {31'd0, miso_oe}, 32'd0);
        hit_rst = 1'b1;
        break;
      end
      mosi = word[31-i];
      repeat (4) @(negedge clk);
      if (i >= 16) rdata = {rdata[14:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (i == 20) oe_mid = miso_oe;
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    if (hit_rst) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    logic [15:0] unused_rd;
    exp_wr.push_back({a, d});
    model_regs[a[3:0]] = d;
    wr_exp++;
    spi_xfer({8'h80, a}, d, 32, 1'b0, unused_rd);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a);
    logic [15:0] got;
    exp_rd.push_back((a < 8'd16) ? model_regs[a[3:0]] : 16'h0000);
    if (a >= 8'd16) err_exp++;
    spi_xfer({8'h00, a}, 16'h0000, 32, 1'b0, got);
    check(tag, {16'd0, got}, {16'd0, exp_rd.pop_front()});
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rdv;
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; dbg_addr = 8'd3;
    oe_mid = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
    repeat (5) @(negedge clk);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    for (int i = 0; i < 16; i++) dbg_check("rst_reg", 8'(i), 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_write(8'd3, 16'hA5C3);
    check("oe_mid_frame", {31'd0, oe_mid}, 32'd1);
    check("oe_after_frame", {31'd0, miso_oe}, 32'd0);
    dbg_check("dbg3_after_wr", 8'd3, 16'hA5C3);
    check("wr_count_1", wr_seen, wr_exp);
    check("no_err_1", err_seen, err_exp);

    do_read("read_a5c3", 8'd3);
    dbg_check("dbg3_after_rd", 8'd3, 16'hA5C3);
    check("wr_count_rd", wr_seen, wr_exp);

    spi_xfer(16'h8005, 16'h1234, 20, 1'b0, rdv);
    err_exp++;
    check("abort_err", err_seen, err_exp);
    check("abort_no_wr", wr_seen, wr_exp);
    dbg_check("abort_reg5", 8'd5, 16'h0000);
    do_write(8'd5, 16'h5A5A);
    dbg_check("after_abort_reg5", 8'd5, 16'h5A5A);

    spi_xfer(16'h8020, 16'hFFFF, 32, 1'b0, rdv);
    err_exp++;
    check("oor_wr_err", err_seen, err_exp);
    check("oor_wr_no_strobe", wr_seen, wr_exp);
    do_read("oor_read_zero", 8'h20);
    check("oor_rd_err", err_seen, err_exp);
    dbg_check("dbg_oor", 8'h20, 16'h0000);

    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(0, 15));
      do_write(ra, 16'($urandom));
      do_read("rand_readback", ra);
    end
    for (int i = 0; i < 16; i++) dbg_check("model_reg", 8'(i), model_regs[i]);

    spi_xfer(16'h8007, 16'hBEEF, 32, 1'b1, rdv);
    for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
    check("rst_mid_oe", {31'd0, miso_oe}, 32'd0);
    dbg_check("rst_mid_reg7", 8'd7, 16'h0000);
    dbg_check("rst_mid_reg3", 8'd3, 16'h0000);

    do_write(8'd9, 16'h1111);
    do_write(8'd9, 16'h2222);
    dbg_check("b2b_reg9", 8'd9, 16'h2222);
    do_read("b2b_read9", 8'd9);

    repeat (10) @(negedge clk);
    check("wr_total", wr_seen, wr_exp);
    check("err_total", err_seen, err_exp);
    check("wr_queue_empty", exp_wr.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
